// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Two-stage issue/response controller wrapped around an external
//   combinational ALU.
//   Stage E registers the operands and the decoded ALU control (plus the
//   branch kind and an illegal flag) and drives them straight to the ALU.
//   Stage R captures the ALU answer and derives the branch-taken bit.
//   Both stages use valid/ready handshakes, so full throughput is one
//   request per cycle.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   in_valid / in_ready             upstream request handshake
//   alu_op, funct3, funct7          decode fields
//   op_a, op_b                      operands
//   alu_in1, alu_in2, alu_ctrl      drive to the external ALU (from stage E)
//   alu_result, alu_zero            ALU answer, valid in the same cycle
//   out_valid / out_ready           downstream response handshake
//   out_result, out_zero,
//   out_taken, out_illegal          response payload (from stage R)
//   illegal_count                   saturating count of accepted illegal requests
module alu_issue_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} br_t;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  // Plain R-type mapping with funct7 = 0000000.
  function automatic logic [3:0] base_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:         base_ctrl = 4'b0010; // ADD
      3'b001:         base_ctrl = 4'b0110; // SLL
      3'b010, 3'b011: base_ctrl = 4'b0101; // SLT
      3'b100:         base_ctrl = 4'b0100; // XOR
      3'b101:         base_ctrl = 4'b0111; // SRL
      3'b110:         base_ctrl = 4'b0001; // OR
      default:        base_ctrl = 4'b0000; // AND
    endcase
  endfunction

  // Stage E
  logic        r_e_valid;
  logic [31:0] r_alu_in1;
  logic [31:0] r_alu_in2;
  logic [3:0]  r_alu_ctrl;
  br_t         r_e_br;
  logic        r_e_illegal;
  // Stage R
  logic        r_r_valid;
  logic [31:0] r_out_result;
  logic        r_out_zero;
  logic        r_out_taken;
  logic        r_out_illegal;
  logic [CNT_W-1:0] r_illegal_count;

  logic [3:0] w_ctrl;
  logic       w_illegal;
  br_t        w_br;
  logic       w_transfer;
  logic       w_accept;
  logic       w_taken;

  always_comb begin
    w_ctrl    = 4'b0010;
    w_illegal = 1'b0;
    w_br      = BR_NONE;
    case (alu_op)
      2'b00: w_ctrl = 4'b0010;
      2'b10: begin
        if (funct7 == F7_ZERO)                        w_ctrl = base_ctrl(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) w_ctrl = 4'b0011; // SUB
        else if (funct7 == F7_ALT && funct3 == 3'b101) w_ctrl = 4'b1000; // SRA
        else                                          w_illegal = 1'b1;
      end
      2'b11: begin
        // Immediate forms: funct7 only carries meaning for the shifts.
        case (funct3)
          3'b000: w_ctrl = 4'b0010;
          3'b001: begin
            if (funct7 == F7_ZERO) w_ctrl = 4'b0110;
            else                   w_illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_ZERO)     w_ctrl = 4'b0111;
            else if (funct7 == F7_ALT) w_ctrl = 4'b1000;
            else                       w_illegal = 1'b1;
          end
          default: w_ctrl = base_ctrl(funct3);
        endcase
      end
      default: begin
        case (funct3)
          3'b000:         begin w_ctrl = 4'b0011; w_br = BR_EQ; end
          3'b001:         begin w_ctrl = 4'b0011; w_br = BR_NE; end
          3'b100, 3'b110: begin w_ctrl = 4'b0101; w_br = BR_LT; end
          3'b101, 3'b111: begin w_ctrl = 4'b0101; w_br = BR_GE; end
          default:        w_illegal = 1'b1;
        endcase
      end
    endcase
    if (w_illegal) begin
      w_ctrl = CTRL_ILLEGAL;
      w_br   = BR_NONE;
    end
  end

  assign w_transfer = r_e_valid && (!r_r_valid || out_ready);
  assign in_ready   = !r_e_valid || w_transfer;
  assign w_accept   = in_valid && in_ready;

  // Illegal requests carry BR_NONE, so they can never report taken.
  always_comb begin
    case (r_e_br)
      BR_EQ:   w_taken = alu_zero;
      BR_NE:   w_taken = !alu_zero;
      BR_LT:   w_taken = alu_result[0];
      BR_GE:   w_taken = !alu_result[0];
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_valid       <= 1'b0;
      r_alu_in1       <= '0;
      r_alu_in2       <= '0;
      r_alu_ctrl      <= CTRL_ILLEGAL;
      r_e_br          <= BR_NONE;
      r_e_illegal     <= 1'b0;
      r_r_valid       <= 1'b0;
      r_out_result    <= '0;
      r_out_zero      <= 1'b0;
      r_out_taken     <= 1'b0;
      r_out_illegal   <= 1'b0;
      r_illegal_count <= '0;
    end else begin
      if (w_accept) begin
        r_e_valid   <= 1'b1;
        r_alu_in1   <= op_a;
        r_alu_in2   <= op_b;
        r_alu_ctrl  <= w_ctrl;
        r_e_br      <= w_br;
        r_e_illegal <= w_illegal;
        if (w_illegal && (r_illegal_count != {CNT_W{1'b1}}))
          r_illegal_count <= r_illegal_count + 1'b1;
      end else if (w_transfer) begin
        r_e_valid <= 1'b0;
      end

      if (w_transfer) begin
        r_r_valid     <= 1'b1;
        r_out_result  <= alu_result;
        r_out_zero    <= alu_zero;
        r_out_taken   <= w_taken;
        r_out_illegal <= r_e_illegal;
      end else if (out_ready && r_r_valid) begin
        r_r_valid <= 1'b0;
      end
    end
  end

  assign alu_in1       = r_alu_in1;
  assign alu_in2       = r_alu_in2;
  assign alu_ctrl      = r_alu_ctrl;
  assign out_valid     = r_r_valid;
  assign out_result    = r_out_result;
  assign out_zero      = r_out_zero;
  assign out_taken     = r_out_taken;
  assign out_illegal   = r_out_illegal;
  assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: models the external combinational ALU, drives
// requests through a send task and checks responses against a queue of
// expected payloads filled when each request is accepted.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_in1, alu_in2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_taken, out_illegal;
  logic [7:0]  illegal_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        taken;
    logic        ill;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
    .op_a(op_a), .op_b(op_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_taken(out_taken),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  // Reference ALU; unknown controls (incl. 1111) produce zero.
  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: alu_model = a & b;
      4'b0001: alu_model = a | b;
      4'b0010: alu_model = a + b;
      4'b0011: alu_model = a - b;
      4'b0100: alu_model = a ^ b;
      4'b0101: alu_model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0110: alu_model = a << b[4:0];
      4'b0111: alu_model = a >> b[4:0];
      4'b1000: alu_model = $unsigned($signed(a) >>> b[4:0]);
      default: alu_model = 32'd0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_ctrl, alu_in1, alu_in2);
  assign alu_zero   = (alu_result == 32'd0);

  // Response monitor: a response is consumed on the next rising edge.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got result=%h illegal=%b, no response expected", out_result, out_illegal);
      end else begin
        mon_e = q.pop_front();
        n_resp++;
        if ({out_result, out_zero, out_taken, out_illegal} !== {mon_e.res, mon_e.zero, mon_e.taken, mon_e.ill}) begin
          n_fail++;
          $display("FAIL resp_payload #%0d: got res=%h z=%b t=%b i=%b, expected res=%h z=%b t=%b i=%b",
                   n_resp, out_result, out_zero, out_taken, out_illegal,
                   mon_e.res, mon_e.zero, mon_e.taken, mon_e.ill);
        end else begin
          $display("resp #%0d: res=%h z=%b t=%b i=%b ok", n_resp, out_result, out_zero, out_taken, out_illegal);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ectrl, input logic etaken);
    exp_t e;
    bit acc = 0;
    int k = 0;
    e.res   = alu_model(ectrl, a, b);
    e.zero  = (e.res == 32'd0);
    e.taken = etaken;
    e.ill   = (ectrl == 4'b1111);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    while (!acc && k < 64) begin
      #1;
      if (in_ready === 1'b1) begin
        acc = 1;
        q.push_back(e);
      end
      @(posedge clk);
      if (!acc) @(negedge clk);
      k++;
    end
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: op=%b f3=%b not accepted within 64 cycles", op, f3);
    end else if ({alu_ctrl, alu_in1, alu_in2} !== {ectrl, a, b}) begin
      n_fail++;
      $display("FAIL issue op=%b f3=%b f7=%b: got ctrl=%b in1=%h in2=%h, expected ctrl=%b in1=%h in2=%h",
               op, f3, f7, alu_ctrl, alu_in1, alu_in2, ectrl, a, b);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready, alu_ctrl, alu_in1, alu_in2, out_result, out_zero, out_taken, out_illegal, illegal_count}
        !== {1'b0, 1'b1, 4'b1111, 32'd0, 32'd0, 32'd0, 3'b000, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b ctrl=%b in1=%h res=%h cnt=%0d, expected 0 1 1111 0 0 0",
               out_valid, in_ready, alu_ctrl, alu_in1, out_result, illegal_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    send(2'b10, 3'b001, 7'b0100000, 32'd9, 32'd1, 4'b1111, 1'b0);
    n_checks++;
    if (illegal_count !== 8'd1) begin
      n_fail++;
      $display("FAIL illegal_count_first: got %0d, expected 1", illegal_count);
    end
    send(2'b01, 3'b010, 7'd0, 32'd1, 32'd1, 4'b1111, 1'b0);   // branch funct3 010
    send(2'b10, 3'b000, 7'b0000001, 32'd1, 32'd2, 4'b1111, 1'b0);
    send(2'b11, 3'b001, 7'b0100000, 32'd1, 32'd2, 4'b1111, 1'b0); // SLLI with alt funct7
    drain();
    n_checks++;
    if (illegal_count !== 8'd4) begin
      n_fail++;
      $display("FAIL illegal_count_four: got %0d, expected 4", illegal_count);
    end
  endtask

  task automatic test_rtype();
    send(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd5, 4'b0011, 1'b0); // SUB -> zero
    send(2'b10, 3'b000, 7'b0000000, 32'd5, 32'd7, 4'b0010, 1'b0);
    send(2'b10, 3'b001, 7'b0000000, 32'h1, 32'd31, 4'b0110, 1'b0);
    send(2'b10, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 4'b0101, 1'b0);
    send(2'b10, 3'b011, 7'b0000000, 32'd4, 32'd2, 4'b0101, 1'b0);
    send(2'b10, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100, 1'b0);
    send(2'b10, 3'b101, 7'b0000000, 32'h80000000, 32'd4, 4'b0111, 1'b0);
    send(2'b10, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 4'b1000, 1'b0);
    send(2'b10, 3'b110, 7'b0000000, 32'h00FF0000, 32'h000000FF, 4'b0001, 1'b0);
    send(2'b10, 3'b111, 7'b0000000, 32'hABCD1234, 32'h0000FFFF, 4'b0000, 1'b0);
    drain();
  endtask

  task automatic test_itype();
    send(2'b11, 3'b000, 7'b0100000, 32'd10, 32'd20, 4'b0010, 1'b0);   // ADDI ignores funct7
    send(2'b11, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 4'b1000, 1'b0); // SRAI
    send(2'b11, 3'b101, 7'b0000000, 32'h80000000, 32'd4, 4'b0111, 1'b0); // SRLI
    send(2'b11, 3'b110, 7'b1111111, 32'h10, 32'h01, 4'b0001, 1'b0);    // ORI ignores funct7
    send(2'b11, 3'b101, 7'b0000011, 32'h1, 32'h1, 4'b1111, 1'b0);      // bad shift funct7
    send(2'b00, 3'b111, 7'b1111111, 32'h100, 32'h24, 4'b0010, 1'b0);   // load/store ADD
    drain();
  endtask

  task automatic test_branch();
    send(2'b01, 3'b000, 7'd0, 32'd8, 32'd8, 4'b0011, 1'b1);  // BEQ taken
    send(2'b01, 3'b000, 7'd0, 32'd8, 32'd9, 4'b0011, 1'b0);  // BEQ not taken
    send(2'b01, 3'b001, 7'd0, 32'd3, 32'd7, 4'b0011, 1'b1);  // BNE 3,7
    send(2'b01, 3'b100, 7'd0, 32'd2, 32'd9, 4'b0101, 1'b1);  // BLT taken
    send(2'b01, 3'b110, 7'd0, 32'd9, 32'd2, 4'b0101, 1'b0);  // BLTU not taken
    send(2'b01, 3'b111, 7'd0, 32'd7, 32'd3, 4'b0101, 1'b1);  // BGEU 7,3
    send(2'b01, 3'b101, 7'd0, 32'd1, 32'd5, 4'b0101, 1'b0);  // BGE not taken
    drain();
  endtask

  task automatic test_stall();
    logic [31:0] held_res, held_in1;
    logic [3:0]  held_ctrl;
    @(negedge clk);
    out_ready = 1'b0;
    send(2'b10, 3'b000, 7'd0, 32'd100, 32'd1, 4'b0010, 1'b0);
    send(2'b10, 3'b000, 7'b0100000, 32'd100, 32'd1, 4'b0011, 1'b0);
    held_res = out_result; held_in1 = alu_in1; held_ctrl = alu_ctrl;
    fork
      send(2'b10, 3'b100, 7'd0, 32'h55, 32'hFF, 4'b0100, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk); #2;
          n_checks++;
          if ({in_ready, out_valid, out_result, alu_in1, alu_ctrl} !== {1'b0, 1'b1, held_res, held_in1, held_ctrl}) begin
            n_fail++;
            $display("FAIL stall_hold: got ir=%b ov=%b res=%h in1=%h ctrl=%b, expected 0 1 %h %h %b",
                     in_ready, out_valid, out_result, alu_in1, alu_ctrl, held_res, held_in1, held_ctrl);
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) begin
          #2;
          n_checks++;
          if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got out_valid=%b, expected 1 on each of 3 cycles", out_valid);
          end
          @(negedge clk);
        end
      end
    join
    drain();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++)
      send(2'b10, 3'b010, 7'b0100000, i, 32'd1, 4'b1111, 1'b0);
    drain();
    n_checks++;
    if (illegal_count !== 8'd255) begin
      n_fail++;
      $display("FAIL illegal_saturate: got %0d, expected 255", illegal_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    send(2'b10, 3'b000, 7'd0, 32'd1, 32'd2, 4'b0010, 1'b0);
    send(2'b10, 3'b011, 7'b0100000, 32'd1, 32'd2, 4'b1111, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_pre: got ov=%b ir=%b, expected 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'b001; funct7 = 7'b0100000;
    @(posedge clk); #1;
    q.delete();
    n_checks++;
    if ({out_valid, in_ready, illegal_count, alu_ctrl} !== {1'b0, 1'b1, 8'd0, 4'b1111}) begin
      n_fail++;
      $display("FAIL midreset_state: got ov=%b ir=%b cnt=%0d ctrl=%b, expected 0 1 0 1111",
               out_valid, in_ready, illegal_count, alu_ctrl);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); #2;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_noresp: got out_valid=%b, expected 0", out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_rtype();
    test_itype();
    test_branch();
    test_stall();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
